nbit_seq_comparator: RTL and testbench

- Parametrised, multi-cycle magnitude comparator; successor to the team's fixed 4-bit combinational comparator.
- Compares two WIDTH-bit operands CHUNK bits per cycle, MSB-first, and exits early on the first differing chunk.
- Supports unsigned and two's-complement signed mode.
- Valid/ready handshake on both input and result, so it sits between datapath producers and control consumers without timing closure on a wide compare.

---
 rtl/comparator_pkg.sv | 8 +
 rtl/cmp_chunk.sv | 14 +
 rtl/nbit_seq_comparator.sv | 89 ++++++++
 tb/tb_nbit_seq_comparator.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/comparator_pkg.sv
// comparator_pkg: shared state and result encodings for the sequential comparators
package comparator_pkg;
  typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;
  localparam logic [2:0] CMP_NONE = 3'b000;
  localparam logic [2:0] CMP_GT   = 3'b001;
  localparam logic [2:0] CMP_EQ   = 3'b010;
  localparam logic [2:0] CMP_LT   = 3'b100;
endpackage

// File: rtl/cmp_chunk.sv
// cmp_chunk: combinational unsigned magnitude compare of one chunk
module cmp_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a_c,
  input  logic [CHUNK-1:0] b_c,
  output logic             gt,
  output logic             eq,
  output logic             lt
);
  assign gt = a_c > b_c;
  assign eq = a_c == b_c;
  assign lt = a_c < b_c;
endmodule

// File: rtl/nbit_seq_comparator.sv
// nbit_seq_comparator: MSB-first chunked magnitude compare with early exit and valid/ready handshakes
module nbit_seq_comparator
  import comparator_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       y,
  output logic             busy
);
  localparam int NCHUNK = WIDTH / (CHUNK == 0 ? 1 : CHUNK);
  localparam int CW = NCHUNK > 1 ? $clog2(NCHUNK) : 1;
  localparam logic [WIDTH-1:0] MSB = WIDTH'(1) << (WIDTH - 1);
  if (CHUNK == 0 || WIDTH % (CHUNK == 0 ? 1 : CHUNK) != 0) begin : g_bad_param
    $fatal(1, "WIDTH must be a non-zero multiple of CHUNK");
  end
  state_t           state, state_d;
  logic [WIDTH-1:0] sa, sb, sa_d, sb_d;
  logic [CW-1:0]    cnt, cnt_d;
  logic [2:0]       y_q, y_d;
  logic             gt, eq, lt, last;
  cmp_chunk #(.CHUNK(CHUNK)) u_cmp (
    .a_c(sa[WIDTH-1 -: CHUNK]),
    .b_c(sb[WIDTH-1 -: CHUNK]),
    .gt (gt),
    .eq (eq),
    .lt (lt)
  );
  assign last      = cnt == CW'(NCHUNK - 1);
  assign in_ready  = state == IDLE;
  assign busy      = state != IDLE;
  assign out_valid = state == DONE;
  assign y         = y_q;
  // state, operand shift registers, chunk counter and held result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sa    <= '0;
      sb    <= '0;
      cnt   <= '0;
      y_q   <= CMP_NONE;
    end else begin
      state <= state_d;
      sa    <= sa_d;
      sb    <= sb_d;
      cnt   <= cnt_d;
      y_q   <= y_d;
    end
  end
  // next state: latch (MSB-flipped when signed), walk chunks MSB-first, hold result until taken
  always_comb begin
    state_d = state;
    sa_d    = sa;
    sb_d    = sb;
    cnt_d   = cnt;
    y_d     = y_q;
    case (state)
      IDLE: if (in_valid) begin
        sa_d    = a ^ (signed_mode ? MSB : '0);
        sb_d    = b ^ (signed_mode ? MSB : '0);
        cnt_d   = '0;
        state_d = CMP;
      end
      CMP: begin
        y_d     = gt ? CMP_GT : lt ? CMP_LT : last ? CMP_EQ : CMP_NONE;
        state_d = (eq && !last) ? CMP : DONE;
        if (eq && !last) begin
          sa_d  = sa << CHUNK;
          sb_d  = sb << CHUNK;
          cnt_d = cnt + CW'(1);
        end
      end
      DONE: if (out_ready) begin
        y_d     = CMP_NONE;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_nbit_seq_comparator.sv
// tb_nbit_seq_comparator: scoreboard bench with directed and random compares against an arithmetic model
module tb_nbit_seq_comparator;
  localparam int W = 16;
  localparam int C = 4;
  localparam int N = W / C;
  typedef struct {
    logic [2:0] y;
    int         lat;
    int         acc;
  } exp_t;
  logic         clk = 0;
  logic         rst_n = 0;
  logic         in_valid = 0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         signed_mode = 0;
  logic         out_valid;
  logic         out_ready = 0;
  logic [2:0]   y;
  logic         busy;
  exp_t         q[$];
  int           cyc = 0;
  int           vec = 0;
  int           errs = 0;
  int           hold = 0;
  nbit_seq_comparator #(.WIDTH(W), .CHUNK(C)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .signed_mode(signed_mode),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .y          (y),
    .busy       (busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask
  function automatic logic [2:0] model_y(input logic [W-1:0] x, input logic [W-1:0] z, input logic sm);
    logic signed [W:0] sx, sz;
    sx = sm ? {x[W-1], x} : {1'b0, x};
    sz = sm ? {z[W-1], z} : {1'b0, z};
    return sx > sz ? 3'b001 : sx < sz ? 3'b100 : 3'b010;
  endfunction
  function automatic int model_lat(input logic [W-1:0] x, input logic [W-1:0] z);
    for (int i = 0; i < N; i++)
      if (x[W-1-C*i -: C] != z[W-1-C*i -: C]) return i + 1;
    return N;
  endfunction
  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic sm);
    int t = 0;
    exp_t e;
    @(negedge clk);
    a = ta;
    b = tb;
    signed_mode = sm;
    in_valid = 1;
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 0, 1);
      in_valid = 0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    e.y = model_y(ta, tb, sm);
    e.lat = model_lat(ta, tb);
    e.acc = cyc;
    q.push_back(e);
    vec++;
    in_valid = 0;
    a = W'($urandom);
    b = W'($urandom);
    signed_mode = 1'($urandom);
  endtask
  // consumer: random backpressure, or a forced stall while hold is non-zero
  initial forever begin
    @(negedge clk);
    if (hold > 0) begin
      out_ready = 0;
      hold--;
    end else out_ready = $urandom_range(0, 3) != 0;
  end
  // monitor: pop on each new result, check value and latency, and the output invariants every cycle
  initial begin
    logic       prev_ov = 0;
    logic [2:0] prev_y = '0;
    exp_t       e;
    forever begin
      @(negedge clk);
      if (out_valid && !prev_ov) begin
        if (q.size() == 0) chk("unexpected_result", {29'd0, y}, 32'hFFFF_FFFF);
        else begin
          e = q.pop_front();
          chk("result_y", {29'd0, y}, {29'd0, e.y});
          chk("latency", cyc - e.acc, e.lat);
        end
      end
      if (out_valid && prev_ov) chk("y_held", {29'd0, y}, {29'd0, prev_y});
      if (out_valid) begin
        chk("onehot", {31'd0, $onehot(y)}, 1);
        chk("ready_busy_in_done", {30'd0, in_ready, busy}, 32'b01);
      end else chk("y_idle_zero", {29'd0, y}, 0);
      prev_ov = out_valid;
      prev_y = y;
    end
  end
  initial begin
    logic [W-1:0] ra, rb;
    int t;
    #1;
    chk("reset_y", {29'd0, y}, 0);
    chk("reset_out_valid", {31'd0, out_valid}, 0);
    chk("reset_busy", {31'd0, busy}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    #1;
    chk("reset_in_ready", {31'd0, in_ready}, 1);
    send(16'h1234, 16'h1234, 0);
    send(16'h8000, 16'h7FFF, 0);
    send(16'h8000, 16'h7FFF, 1);
    send(16'h12A4, 16'h12B4, 0);
    send(16'hFFFF, 16'h0001, 1);
    send(16'h0000, 16'h0000, 1);
    send(16'h7FFF, 16'hFFFF, 1);
    hold = 30;
    send(16'h0001, 16'h0000, 0);
    send(16'h0000, 16'h0001, 0);
    send(16'h1234, 16'h1234, 0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 0;
    #1;
    chk("abort_y", {29'd0, y}, 0);
    chk("abort_out_valid", {31'd0, out_valid}, 0);
    chk("abort_in_ready", {31'd0, in_ready}, 1);
    chk("abort_busy", {31'd0, busy}, 0);
    if (q.size() > 0) void'(q.pop_back());
    @(negedge clk);
    rst_n = 1;
    send(16'h0005, 16'h0003, 0);
    for (int i = 0; i < 300; i++) begin
      ra = W'($urandom);
      case ($urandom_range(0, 3))
        0: rb = ra;
        1: rb = ra ^ W'(1 << $urandom_range(0, W - 1));
        2: rb = W'($urandom_range(0, 15)) ^ (ra & 16'hFFF0);
        default: rb = W'($urandom);
      endcase
      send(ra, rb, 1'($urandom));
    end
    t = 0;
    while (q.size() > 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (q.size() > 0) chk("drain_timeout", q.size(), 0);
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
